// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control FSM.
// Latency: n/a (types, constants and one pure function only).
// Backpressure: n/a.
//
// Contents:
//   - state encodings (FETCH..TRAP) as fixed-width constants
//   - the opcodes the FSM recognises
//   - datapath mux-select encodings
//   - ctrl_t, a packed bundle of every control output
//   - decode_target(), which picks the state that follows DECODE
package ctrl_pkg;

    // ------------------------------------------------------------------
    // FSM state encodings. Explicit values keep the encoding stable for
    // anything that probes the state register by number.
    // ------------------------------------------------------------------
    typedef logic [3:0] state_t;

    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_MEMADR   = 4'd2;
    localparam state_t S_MEMREAD  = 4'd3;
    localparam state_t S_MEMWB    = 4'd4;
    localparam state_t S_MEMWRITE = 4'd5;
    localparam state_t S_EXECR    = 4'd6;
    localparam state_t S_EXECI    = 4'd7;
    localparam state_t S_ALUWB    = 4'd8;
    localparam state_t S_JAL      = 4'd9;
    localparam state_t S_BEQ      = 4'd10;
    localparam state_t S_TRAP     = 4'd11;

    // ------------------------------------------------------------------
    // Opcodes (instr[6:0]) handled by this core.
    // ------------------------------------------------------------------
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    // ------------------------------------------------------------------
    // Mux-select encodings.
    // ------------------------------------------------------------------
    // Result mux (what gets written back / fed to the PC).
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    // ALU operand A.
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALU operand B.
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // ALU operation class.
    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;

    // Memory address mux.
    localparam logic ADR_PC     = 1'b0;
    localparam logic ADR_ALUOUT = 1'b1;

    // ------------------------------------------------------------------
    // Every control output in one bundle. The all-zero value is the
    // "nothing happens" word: no strobes, every select at its 0 leg.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    // ------------------------------------------------------------------
    // State entered after DECODE. Loads and stores share the address
    // phase; anything unrecognised parks the core in TRAP.
    // ------------------------------------------------------------------
    function automatic state_t decode_target(input logic [6:0] op);
        state_t nxt;
        case (op)
            OP_LW, OP_SW: nxt = S_MEMADR;
            OP_R:         nxt = S_EXECR;
            OP_I:         nxt = S_EXECI;
            OP_JAL:       nxt = S_JAL;
            OP_BEQ:       nxt = S_BEQ;
            default:      nxt = S_TRAP;
        endcase
        return nxt;
    endfunction

endpackage : ctrl_pkg

// File: rtl/ctrl_out_decode.sv
// Output decode for the control FSM: current state + mem_ready -> ctrl bundle.
// Latency: purely combinational, zero cycles.
// Backpressure: mem_ready=0 suppresses the FETCH strobes (IR/PC updates).
//
// Ports:
//   state     in   current FSM state
//   mem_ready in   memory access completes this cycle
//   ctrl      out  every datapath select and write strobe
//
// Outputs are a Moore decode of the state. The one exception is FETCH,
// where ir_write and pc_write follow mem_ready directly. That way the
// instruction word is captured in the very cycle the memory delivers it.
module ctrl_out_decode
    import ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = CTRL_IDLE;
        case (state)
            S_FETCH: begin
                // Read instr at PC and compute PC+4 in parallel.
                // PC+4 goes straight from the ALU result into the PC.
                ctrl.adr_src    = ADR_PC;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALU_ADD;
                ctrl.result_src = RES_ALURES;
                ctrl.ir_write   = mem_ready;
                ctrl.pc_write   = mem_ready;
            end
            S_DECODE: begin
                // Speculatively form OldPC + imm.
                // This is the branch/jump target, used later from ALUOut.
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.alu_op     = ALU_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.alu_op     = ALU_ADD;
            end
            S_MEMREAD: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.adr_src    = ADR_ALUOUT;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                // The write strobe is held for the whole wait.
                // A slow memory sees a stable request until it is ready.
                ctrl.result_src = RES_ALUOUT;
                ctrl.adr_src    = ADR_ALUOUT;
                ctrl.mem_write  = 1'b1;
            end
            S_EXECR: begin
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_RS2;
                ctrl.alu_op     = ALU_FUNCT;
            end
            S_EXECI: begin
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.alu_op     = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
            end
            S_JAL: begin
                // Jump to the target held in ALUOut since DECODE.
                // Meanwhile the ALU forms OldPC+4, which ALUWB writes to rd.
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALU_ADD;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_write   = 1'b1;
            end
            S_BEQ: begin
                // The ALU subtract sets zero.
                // The datapath ANDs zero with branch to take the ALUOut target.
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_RS2;
                ctrl.alu_op     = ALU_SUB;
                ctrl.result_src = RES_ALUOUT;
                ctrl.branch     = 1'b1;
            end
            default: begin
                // TRAP and unused encodings: everything idle.
                ctrl = CTRL_IDLE;
            end
        endcase
    end

endmodule : ctrl_out_decode

// File: rtl/main_ctrl_fsm.sv
// Multicycle RV32I control FSM: fetch/decode/execute/memory/writeback sequencing.
// Latency: lw 5, sw 4, R/I/jal 4, beq 3 cycles at mem_ready=1; +1 per stall cycle.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold their state while mem_ready=0.
//
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   opcode          instr[6:0] from the IR (stable from DECODE onward)
//   mem_ready       memory access completes this cycle
//   pc_write, branch, mem_write, ir_write, reg_write   write strobes
//   adr_src, result_src, alu_src_a, alu_src_b, alu_op   datapath mux selects
//   illegal_instr   sticky flag, set on an unsupported opcode, cleared by reset
module main_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int OPW = 7
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] opcode,
    input  logic           mem_ready,
    output logic           pc_write,
    output logic           branch,
    output logic           adr_src,
    output logic           mem_write,
    output logic           ir_write,
    output logic           reg_write,
    output logic [1:0]     result_src,
    output logic [1:0]     alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic [1:0]     alu_op,
    output logic           illegal_instr
);

    state_t state;
    state_t state_nxt;
    logic   illegal_q;
    ctrl_t  ctrl_raw;
    ctrl_t  ctrl_out;

    // ------------------------------------------------------------------
    // State register. Reset lands in FETCH, so the first cycle after
    // release starts a fresh instruction. Nothing from an interrupted
    // sequence survives.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:    state_nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:   state_nxt = decode_target(opcode[6:0]);
            // opcode bit 5 separates stores (0100011) from loads (0000011).
            S_MEMADR:   state_nxt = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_nxt = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_nxt = S_FETCH;
            S_MEMWRITE: state_nxt = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_nxt = S_ALUWB;
            S_EXECI:    state_nxt = S_ALUWB;
            S_ALUWB:    state_nxt = S_FETCH;
            S_JAL:      state_nxt = S_ALUWB;
            S_BEQ:      state_nxt = S_FETCH;
            S_TRAP:     state_nxt = S_TRAP;
            default:    state_nxt = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Sticky illegal-instruction flag.
    // It is set on the edge that enters TRAP, so it reads 1 from the
    // first TRAP cycle. Only reset clears it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else if (state_nxt == S_TRAP) begin
            illegal_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output decode.
    // ------------------------------------------------------------------
    ctrl_out_decode u_ctrl_out_decode (
        .state     (state),
        .mem_ready (mem_ready),
        .ctrl      (ctrl_raw)
    );

    // During reset the state register already reads FETCH. Without
    // gating, FETCH with mem_ready=1 would pulse ir_write/pc_write.
    // The whole bundle is therefore forced idle while rst_n is low.
    // That also cuts off a store held mid-wait the instant reset asserts.
    assign ctrl_out = rst_n ? ctrl_raw : CTRL_IDLE;

    assign pc_write      = ctrl_out.pc_write;
    assign branch        = ctrl_out.branch;
    assign adr_src       = ctrl_out.adr_src;
    assign mem_write     = ctrl_out.mem_write;
    assign ir_write      = ctrl_out.ir_write;
    assign reg_write     = ctrl_out.reg_write;
    assign result_src    = ctrl_out.result_src;
    assign alu_src_a     = ctrl_out.alu_src_a;
    assign alu_src_b     = ctrl_out.alu_src_b;
    assign alu_op        = ctrl_out.alu_op;
    assign illegal_instr = illegal_q;

endmodule : main_ctrl_fsm

// File: tb/tb_main_ctrl_fsm.sv
// Directed bench for main_ctrl_fsm.
// Every output is packed into one 15-bit word, and each cycle that word
// is compared against a hand-written constant for the expected state.
// Word layout, MSB first:
//   pc_write, branch, adr_src, mem_write, ir_write, reg_write,
//   result_src[1:0], alu_src_a[1:0], alu_src_b[1:0], alu_op[1:0],
//   illegal_instr
module tb_main_ctrl_fsm;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       pc_write, branch, adr_src, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic       illegal_instr;

    int total_cnt;
    int bad_cnt;

    // Expected output words per state.
    // Each value is taken from the state's output list; unlisted outputs are 0.
    localparam logic [14:0] E_IDLE     = 15'b000000_00_00_00_00_0;
    localparam logic [14:0] E_FETCH1   = 15'b100010_10_00_10_00_0;
    localparam logic [14:0] E_FETCH0   = 15'b000000_10_00_10_00_0;
    localparam logic [14:0] E_DECODE   = 15'b000000_00_01_01_00_0;
    localparam logic [14:0] E_MEMADR   = 15'b000000_00_10_01_00_0;
    localparam logic [14:0] E_MEMREAD  = 15'b001000_00_00_00_00_0;
    localparam logic [14:0] E_MEMWB    = 15'b000001_01_00_00_00_0;
    localparam logic [14:0] E_MEMWRITE = 15'b001100_00_00_00_00_0;
    localparam logic [14:0] E_EXECR    = 15'b000000_00_10_00_10_0;
    localparam logic [14:0] E_ALUWB    = 15'b000001_00_00_00_00_0;
    localparam logic [14:0] E_JAL      = 15'b100000_00_01_10_00_0;
    localparam logic [14:0] E_BEQ      = 15'b010000_00_10_00_01_0;
    localparam logic [14:0] E_TRAP     = 15'b000000_00_00_00_00_1;

    logic [14:0] obs;
    assign obs = {pc_write, branch, adr_src, mem_write, ir_write, reg_write,
                  result_src, alu_src_a, alu_src_b, alu_op, illegal_instr};

    main_ctrl_fsm #(.OPW(7)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .branch        (branch),
        .adr_src       (adr_src),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .result_src    (result_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .illegal_instr (illegal_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One cycle.
    // On the falling edge, drive mem_ready for the rest of the cycle.
    // After the combinational outputs settle, compare against exp.
    task automatic step(input string tag, input logic mr, input logic [14:0] exp);
        @(negedge clk);
        mem_ready = mr;
        #1;
        chk(tag, {17'd0, obs}, {17'd0, exp});
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        rst_n     = 1'b0;
        opcode    = 7'b0110011;
        mem_ready = 1'b0;

        // ---- Reset: everything idle even with mem_ready=1 ----
        repeat (3) @(negedge clk);
        mem_ready = 1'b1;
        #1;
        chk("reset_outputs", {17'd0, obs}, {17'd0, E_IDLE});

        // ---- 1: R-type, no stalls ----
        rst_n = 1'b1;
        #1;
        chk("r_fetch", {17'd0, obs}, {17'd0, E_FETCH1});
        step("r_decode", 1'b1, E_DECODE);
        step("r_execr",  1'b1, E_EXECR);
        step("r_aluwb",  1'b1, E_ALUWB);

        // ---- 2: lw, 2 fetch stalls + 3 memread stalls = 10 cycles ----
        @(negedge clk);
        opcode    = 7'b0000011;
        mem_ready = 1'b0;
        #1;
        chk("lw_fetch_stall0", {17'd0, obs}, {17'd0, E_FETCH0});
        step("lw_fetch_stall1", 1'b0, E_FETCH0);
        step("lw_fetch",        1'b1, E_FETCH1);
        step("lw_decode",       1'b1, E_DECODE);
        step("lw_memadr",       1'b1, E_MEMADR);
        for (int i = 0; i < 3; i++) step("lw_memread_stall", 1'b0, E_MEMREAD);
        step("lw_memread",      1'b1, E_MEMREAD);
        step("lw_memwb",        1'b1, E_MEMWB);

        // ---- 3: sw, 2 memwrite stalls ----
        @(negedge clk);
        opcode    = 7'b0100011;
        mem_ready = 1'b1;
        #1;
        chk("sw_fetch", {17'd0, obs}, {17'd0, E_FETCH1});
        step("sw_decode",         1'b1, E_DECODE);
        step("sw_memadr",         1'b1, E_MEMADR);
        step("sw_memwrite_stall", 1'b0, E_MEMWRITE);
        step("sw_memwrite_stall", 1'b0, E_MEMWRITE);
        step("sw_memwrite",       1'b1, E_MEMWRITE);

        // ---- 4: beq (3 cycles) ----
        @(negedge clk);
        opcode    = 7'b1100011;
        mem_ready = 1'b1;
        #1;
        chk("sw_to_fetch", {17'd0, obs}, {17'd0, E_FETCH1});
        step("beq_decode", 1'b1, E_DECODE);
        step("beq_beq",    1'b1, E_BEQ);

        // ---- 5: jal ----
        @(negedge clk);
        opcode    = 7'b1101111;
        mem_ready = 1'b1;
        #1;
        chk("beq_to_fetch", {17'd0, obs}, {17'd0, E_FETCH1});
        step("jal_decode", 1'b1, E_DECODE);
        step("jal_jal",    1'b1, E_JAL);
        step("jal_aluwb",  1'b1, E_ALUWB);

        // ---- 6: illegal opcode -> TRAP, sticky, then async reset ----
        @(negedge clk);
        opcode    = 7'b1111111;
        mem_ready = 1'b1;
        #1;
        chk("jal_to_fetch", {17'd0, obs}, {17'd0, E_FETCH1});
        step("ill_decode", 1'b1, E_DECODE);
        for (int i = 0; i < 20; i++) step("ill_trap", 1'b1, E_TRAP);
        // Assert reset between edges; outputs must clear at once.
        #2;
        rst_n = 1'b0;
        #1;
        chk("ill_async_reset", {17'd0, obs}, {17'd0, E_IDLE});
        chk("ill_flag_cleared", {31'd0, illegal_instr}, 32'd0);
        @(negedge clk);
        opcode = 7'b0110011;
        rst_n  = 1'b1;
        #1;
        chk("ill_resume_fetch", {17'd0, obs}, {17'd0, E_FETCH1});
        step("ill_resume_decode", 1'b1, E_DECODE);
        step("ill_resume_execr",  1'b1, E_EXECR);
        step("ill_resume_aluwb",  1'b1, E_ALUWB);

        // ---- Reset in the middle of a stalled store: write dropped ----
        @(negedge clk);
        opcode    = 7'b0100011;
        mem_ready = 1'b1;
        #1;
        chk("sw2_fetch", {17'd0, obs}, {17'd0, E_FETCH1});
        step("sw2_decode",   1'b1, E_DECODE);
        step("sw2_memadr",   1'b1, E_MEMADR);
        step("sw2_memwrite", 1'b0, E_MEMWRITE);
        #2;
        rst_n = 1'b0;
        #1;
        chk("sw2_reset_kills_write", {31'd0, mem_write}, 32'd0);
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n     = 1'b1;
        #1;
        chk("sw2_back_to_fetch", {17'd0, obs}, {17'd0, E_FETCH0});

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule : tb_main_ctrl_fsm
